// File: rtl/dds_freq_ramp.sv
// dds_freq_ramp: tuning-word ramp generator feeding one dds_slave channel.
// Steps freq_out from freq_start towards freq_stop every max(step_interval,1)
// clocks, clamping the last step onto freq_stop, and pulses synch on every
// change of freq_out. Single ramp ends with a done pulse; continuous mode
// restarts from freq_start one interval after reaching freq_stop.
module dds_freq_ramp #(
    parameter int FW = 32,
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          mode,
    input  logic [FW-1:0] freq_start,
    input  logic [FW-1:0] freq_stop,
    input  logic [FW-1:0] freq_step,
    input  logic [TW-1:0] step_interval,
    output logic [FW-1:0] freq_out,
    output logic          synch,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        STEP,
        FINISH
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [TW-1:0] cnt;
    logic [TW-1:0] cnt_n;
    logic [FW-1:0] freq_n;
    logic          busy_n;
    logic          done_n;
    logic          latch;

    // Configuration captured at start; held for the whole ramp.
    logic [FW-1:0] cfg_start;
    logic [FW-1:0] cfg_stop;
    logic [FW-1:0] cfg_step;
    logic [TW-1:0] cfg_reload;
    logic          cfg_mode;
    logic          dir_up;

    logic [TW-1:0] in_reload;
    logic [FW:0]   gap;
    logic [FW-1:0] stepped;
    logic [FW-1:0] step_next;

    // A zero interval behaves like one: reload value is interval-1, floored at 0.
    assign in_reload = (step_interval == '0) ? '0 : step_interval - TW'(1);

    // Next tuning word: distance to freq_stop is taken one bit wider so the
    // clamp decision never wraps; a zero step jumps straight to freq_stop.
    always_comb begin
        if (dir_up) begin
            gap     = {1'b0, cfg_stop} - {1'b0, freq_out};
            stepped = freq_out + cfg_step;
        end else begin
            gap     = {1'b0, freq_out} - {1'b0, cfg_stop};
            stepped = freq_out - cfg_step;
        end
        if ((cfg_step == '0) || (gap <= {1'b0, cfg_step})) begin
            step_next = cfg_stop;
        end else begin
            step_next = stepped;
        end
    end

    // Next-state and next-output logic; abort overrides everything outside IDLE.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        freq_n  = freq_out;
        busy_n  = busy;
        done_n  = 1'b0;
        latch   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    latch   = 1'b1;
                    state_n = LOAD;
                    freq_n  = freq_start;
                    busy_n  = 1'b1;
                    cnt_n   = in_reload;
                end
            end
            LOAD, WAIT: begin
                if (cnt == '0) begin
                    state_n = STEP;
                    freq_n  = step_next;
                    cnt_n   = cfg_reload;
                end else begin
                    state_n = WAIT;
                    cnt_n   = cnt - TW'(1);
                end
            end
            STEP: begin
                if (freq_out == cfg_stop) begin
                    if (!cfg_mode) begin
                        state_n = FINISH;
                        done_n  = 1'b1;
                    end else if (cnt == '0) begin
                        state_n = LOAD;
                        freq_n  = cfg_start;
                        cnt_n   = cfg_reload;
                    end else begin
                        state_n = FINISH;
                        cnt_n   = cnt - TW'(1);
                    end
                end else if (cnt == '0) begin
                    state_n = STEP;
                    freq_n  = step_next;
                    cnt_n   = cfg_reload;
                end else begin
                    state_n = WAIT;
                    cnt_n   = cnt - TW'(1);
                end
            end
            FINISH: begin
                if (!cfg_mode) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else if (cnt == '0) begin
                    state_n = LOAD;
                    freq_n  = cfg_start;
                    cnt_n   = cfg_reload;
                end else begin
                    cnt_n = cnt - TW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
        if (abort && (state != IDLE)) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            freq_n  = freq_out;
            cnt_n   = '0;
        end
    end

    // State and output registers; synch flags exactly the cycles freq_out moves.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            freq_out <= '0;
            synch    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            freq_out <= freq_n;
            synch    <= (freq_n != freq_out);
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Configuration capture on an accepted start.
    always_ff @(posedge clk) begin
        if (latch) begin
            cfg_start  <= freq_start;
            cfg_stop   <= freq_stop;
            cfg_step   <= freq_step;
            cfg_reload <= in_reload;
            cfg_mode   <= mode;
            dir_up     <= (freq_stop >= freq_start);
        end
    end

endmodule

// File: tb/tb_dds_freq_ramp.sv
// Bench for dds_freq_ramp: a sequence-level reference model (the full list of
// tuning words of a ramp, indexed by cycles since start) checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_dds_freq_ramp;

    localparam int MAXL = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        mode;
    logic [31:0] freq_start;
    logic [31:0] freq_stop;
    logic [31:0] freq_step;
    logic [15:0] step_interval;
    logic [31:0] freq_out;
    logic        synch;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dds_freq_ramp #(.FW(32), .TW(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .mode         (mode),
        .freq_start   (freq_start),
        .freq_stop    (freq_stop),
        .freq_step    (freq_step),
        .step_interval(step_interval),
        .freq_out     (freq_out),
        .synch        (synch),
        .busy         (busy),
        .done         (done)
    );

    // Reference model state
    logic [31:0] m_seq [MAXL];
    int          m_len;
    int          m_i;
    int          m_j;
    bit          m_run  = 1'b0;
    bit          m_mode = 1'b0;
    bit          m_armed = 1'b0;
    logic [31:0] e_freq;
    bit          e_synch = 1'b0;
    bit          e_busy  = 1'b0;
    bit          e_done  = 1'b0;

    function automatic logic [31:0] next_word(input logic [31:0] cur, input logic [31:0] stop,
                                              input logic [31:0] step);
        if (step == 0) return stop;
        if (stop >= cur) return ((stop - cur) <= step) ? stop : cur + step;
        return ((cur - stop) <= step) ? stop : cur - step;
    endfunction

    // Model: a ramp is the list start, next(start), ... , stop; each entry is
    // shown for I cycles. Single mode: done one cycle after the last entry,
    // idle one cycle later. Continuous mode: the list repeats with period len*I.
    initial begin : model
        logic [31:0] v;
        logic [31:0] prev;
        int          j_last;
        int          pos;
        forever begin
            @(posedge clk);
            prev = e_freq;
            if (reset === 1'b0) begin
                m_run   = 1'b0;
                e_freq  = 32'h0;
                e_done  = 1'b0;
                e_synch = 1'b0;
                m_armed = 1'b1;
            end else begin
                if (m_run && abort) begin
                    m_run  = 1'b0;
                    e_done = 1'b0;
                end else if (!m_run && start && !abort) begin
                    v         = freq_start;
                    m_seq[0]  = v;
                    m_len     = 1;
                    do begin
                        v            = next_word(v, freq_stop, freq_step);
                        m_seq[m_len] = v;
                        m_len++;
                    end while ((v != freq_stop) && (m_len < MAXL));
                    m_i    = (step_interval == 0) ? 1 : int'(step_interval);
                    m_mode = mode;
                    m_j    = 1;
                    m_run  = 1'b1;
                    e_freq = m_seq[0];
                    e_done = 1'b0;
                end else if (m_run) begin
                    m_j++;
                    j_last = 1 + (m_len - 1) * m_i;
                    if (m_mode) begin
                        pos    = ((m_j - 1) % (m_len * m_i)) / m_i;
                        e_freq = m_seq[pos];
                    end else begin
                        if (m_j <= j_last) e_freq = m_seq[(m_j - 1) / m_i];
                        e_done = (m_j == j_last + 1);
                        m_run  = (m_j <= j_last + 1);
                    end
                end else begin
                    e_done = 1'b0;
                end
                e_synch = (e_freq != prev);
            end
            e_busy = m_run;
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (m_armed) begin
                total++;
                if ((freq_out !== e_freq) || (synch !== e_synch) || (busy !== e_busy) ||
                    (done !== e_done)) begin
                    bad++;
                    $display("FAIL cycle_check t=%0t: got freq_out=%h synch=%b busy=%b done=%b, want freq_out=%h synch=%b busy=%b done=%b",
                             $time, freq_out, synch, busy, done, e_freq, e_synch, e_busy, e_done);
                end
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    task automatic set_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                           input logic [15:0] iv, input logic md);
        freq_start    = s;
        freq_stop     = e;
        freq_step     = st;
        step_interval = iv;
        mode          = md;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0) && (n < 5000)) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, want 0", busy, n);
        end
        @(negedge clk);
    endtask

    task automatic rand_cfg();
        logic [31:0] st;
        logic [31:0] span;
        logic [31:0] s;
        logic [31:0] e;
        logic [31:0] t;
        int          n;
        int          kind;
        n    = int'($urandom_range(1, 8));
        st   = 32'($urandom_range(1, 32'h0010_0000));
        span = st * 32'(n) - 32'($urandom_range(0, st - 1));
        kind = int'($urandom_range(0, 9));
        s    = 32'($urandom_range(0, 32'h7FFF_FFFF));
        e    = s + span;
        if (kind == 0) st = 32'h0;
        if (kind == 1) e = s;
        if (kind == 2) begin
            e = 32'hFFFF_FFFF;
            s = e - span;
        end
        if (kind == 3) begin
            s = span;
            e = 32'h0;
        end
        if (kind >= 6) begin
            t = s;
            s = e;
            e = t;
        end
        set_cfg(s, e, st, 16'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0));
    endtask

    initial begin : stim
        int dur;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(32'h0, 32'h0, 32'h0, 16'h0, 1'b0);
        repeat (3) @(negedge clk);
        lit("reset_freq", freq_out, 32'h0);
        lit("reset_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Up ramp, interval 4
        set_cfg(32'h100, 32'h400, 32'h100, 16'd4, 1'b0);
        pulse_start();
        lit("up_load_freq", freq_out, 32'h100);
        lit("up_load_synch", 32'(synch), 32'h1);
        lit("up_load_busy", 32'(busy), 32'h1);
        repeat (4) @(negedge clk);
        lit("up_step1", freq_out, 32'h200);
        repeat (4) @(negedge clk);
        lit("up_step2", freq_out, 32'h300);
        repeat (4) @(negedge clk);
        lit("up_step3", freq_out, 32'h400);
        @(negedge clk);
        lit("up_done", 32'(done), 32'h1);
        @(negedge clk);
        lit("up_idle_busy", 32'(busy), 32'h0);
        lit("up_hold", freq_out, 32'h400);

        // Reset mid-ramp
        set_cfg(32'h100, 32'h400, 32'h100, 16'd4, 1'b0);
        pulse_start();
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        lit("midreset_freq", freq_out, 32'h0);
        lit("midreset_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Down ramp with clamp, interval 1
        set_cfg(32'h1000, 32'h0F80, 32'h30, 16'd1, 1'b0);
        pulse_start();
        lit("down_0", freq_out, 32'h1000);
        @(negedge clk);
        lit("down_1", freq_out, 32'h0FD0);
        @(negedge clk);
        lit("down_2", freq_out, 32'h0FA0);
        @(negedge clk);
        lit("down_clamp", freq_out, 32'h0F80);
        @(negedge clk);
        lit("down_done", 32'(done), 32'h1);
        wait_idle();

        // Wrap guard near the top of the range
        set_cfg(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd1, 1'b0);
        pulse_start();
        @(negedge clk);
        lit("wrap_1", freq_out, 32'hFFFF_FF80);
        @(negedge clk);
        lit("wrap_2", freq_out, 32'hFFFF_FFFF);
        wait_idle();

        // Continuous sawtooth, then abort
        set_cfg(32'h10, 32'h30, 32'h10, 16'd2, 1'b1);
        pulse_start();
        repeat (2) @(negedge clk);
        lit("saw_20", freq_out, 32'h20);
        repeat (2) @(negedge clk);
        lit("saw_30", freq_out, 32'h30);
        repeat (2) @(negedge clk);
        lit("saw_reload", freq_out, 32'h10);
        repeat (2) @(negedge clk);
        lit("saw_20b", freq_out, 32'h20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        lit("abort_busy", 32'(busy), 32'h0);
        lit("abort_hold", freq_out, 32'h20);
        lit("abort_synch", 32'(synch), 32'h0);
        repeat (3) @(negedge clk);

        // Start while busy is ignored, config changes after latch ignored
        set_cfg(32'h100, 32'h400, 32'h100, 16'd4, 1'b0);
        pulse_start();
        repeat (2) @(negedge clk);
        set_cfg(32'h9000, 32'h9100, 32'h1, 16'd1, 1'b1);
        pulse_start();
        @(negedge clk);
        lit("busy_start_ignored", freq_out, 32'h200);
        wait_idle();

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        lit("start_abort_busy", 32'(busy), 32'h0);

        // Interval 0 behaves as 1
        set_cfg(32'h10, 32'h30, 32'h10, 16'd0, 1'b0);
        pulse_start();
        @(negedge clk);
        lit("iv0_1", freq_out, 32'h20);
        @(negedge clk);
        lit("iv0_2", freq_out, 32'h30);
        wait_idle();

        // Zero step jumps to stop after one interval
        set_cfg(32'h500, 32'h900, 32'h0, 16'd3, 1'b0);
        pulse_start();
        repeat (2) @(negedge clk);
        lit("step0_hold", freq_out, 32'h500);
        @(negedge clk);
        lit("step0_stop", freq_out, 32'h900);
        @(negedge clk);
        lit("step0_done", 32'(done), 32'h1);
        wait_idle();

        // Randomized ramps with random restarts, aborts and resets
        for (int it = 0; it < 60; it++) begin
            rand_cfg();
            pulse_start();
            dur = mode ? int'($urandom_range(10, 60)) : int'($urandom_range(5, 100));
            for (int c = 0; c < dur; c++) begin
                start = 1'b0;
                abort = 1'b0;
                reset = 1'b1;
                if ($urandom_range(0, 15) == 0) begin
                    rand_cfg();
                    start = 1'b1;
                end
                if ($urandom_range(0, 47) == 0) abort = 1'b1;
                if ($urandom_range(0, 199) == 0) reset = 1'b0;
                @(negedge clk);
            end
            start = 1'b0;
            reset = 1'b1;
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
